// File: rtl/ram_loader_if.sv
// Byte-load handshake plus the machine-bus strobes driven by the RAM loader.
// The loader is the slave of the byte stream and drives the machine bus.
interface ram_loader_if;
    logic       load_valid;
    logic [7:0] load_data;
    logic       load_ready;
    logic [7:0] ext_value;
    logic       en_read_external;
    logic       en_write_mem_adr;
    logic       en_write_mem;

    modport master (
        output load_valid,
        output load_data,
        input  load_ready,
        input  ext_value,
        input  en_read_external,
        input  en_write_mem_adr,
        input  en_write_mem
    );

    modport slave (
        input  load_valid,
        input  load_data,
        output load_ready,
        output ext_value,
        output en_read_external,
        output en_write_mem_adr,
        output en_write_mem
    );
endinterface

// File: rtl/ram_loader.sv
// Loads DEPTH program bytes into the machine RAM over its external-read bus
// while holding the CPU in reset; one byte costs address strobe + data strobe.
//
// state     | meaning
// ----------+---------------------------------------------------------
// IDLE      | waiting for start, machine runs
// WAIT_BYTE | load_ready high, waiting for a byte or abort
// SET_ADR   | drive current address onto bus, latch memory address
// WRITE     | drive captured byte onto bus, write memory, advance addr
// FINISH    | one-cycle done pulse, CPU still held
module ram_loader #(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic            abort,
    ram_loader_if.slave     bus,
    output logic            cpu_hold,
    output logic            busy,
    output logic            done,
    output logic [ADDR_W:0] load_count
);
    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        WAIT_BYTE = 3'd1,
        SET_ADR   = 3'd2,
        WRITE     = 3'd3,
        FINISH    = 3'd4
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W:0]   FULL_COUNT = (ADDR_W + 1)'(DEPTH);

    state_t            state;
    state_t            state_nx;
    logic [ADDR_W-1:0] addr;
    logic [7:0]        byte_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // addr stops at the last location instead of wrapping within a session
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr       <= '0;
            load_count <= '0;
            byte_q     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        addr       <= '0;
                        load_count <= '0;
                    end
                end
                WAIT_BYTE: begin
                    if (!abort && bus.load_valid) begin
                        byte_q <= bus.load_data;
                    end
                end
                WRITE: begin
                    if (addr != LAST_ADDR) begin
                        addr <= addr + 1'b1;
                    end
                    if (load_count != FULL_COUNT) begin
                        load_count <= load_count + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (start) state_nx = WAIT_BYTE;
            end
            WAIT_BYTE: begin
                if (abort) begin
                    state_nx = FINISH;
                end else if (bus.load_valid) begin
                    state_nx = SET_ADR;
                end
            end
            SET_ADR: state_nx = WRITE;
            WRITE: begin
                if (addr == LAST_ADDR || abort) begin
                    state_nx = FINISH;
                end else begin
                    state_nx = WAIT_BYTE;
                end
            end
            FINISH:  state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Moore outputs: decoded from the state register only
    always_comb begin
        bus.load_ready       = 1'b0;
        bus.ext_value        = 8'h00;
        bus.en_read_external = 1'b0;
        bus.en_write_mem_adr = 1'b0;
        bus.en_write_mem     = 1'b0;
        cpu_hold             = 1'b0;
        busy                 = 1'b0;
        done                 = 1'b0;
        case (state)
            WAIT_BYTE: begin
                bus.load_ready = 1'b1;
                cpu_hold       = 1'b1;
                busy           = 1'b1;
            end
            SET_ADR: begin
                bus.en_read_external = 1'b1;
                bus.en_write_mem_adr = 1'b1;
                bus.ext_value        = 8'(addr);
                cpu_hold             = 1'b1;
                busy                 = 1'b1;
            end
            WRITE: begin
                bus.en_read_external = 1'b1;
                bus.en_write_mem     = 1'b1;
                bus.ext_value        = byte_q;
                cpu_hold             = 1'b1;
                busy                 = 1'b1;
            end
            FINISH: begin
                done     = 1'b1;
                cpu_hold = 1'b1;
                busy     = 1'b1;
            end
            default: begin
            end
        endcase
    end
endmodule

// File: doc/ram_loader.md
RAM_LOADER -- requirements
Module: ram_loader

Interface
REQ-001 Parameter DEPTH, default 16, number of RAM bytes loaded per session (power of two, 2..256).
REQ-002 Parameter ADDR_W, default 4, address width; SHALL equal log2(DEPTH).
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 reset  input  1  asynchronous, active-high; clears all state immediately.
REQ-005 start  input  1  one-cycle request to begin a load session; sampled only in IDLE.
REQ-006 abort  input  1  ends the session early; level-sampled.
REQ-007 load_valid  input  1  load_data holds a valid byte.
REQ-008 load_data  input  8  program byte for the current address.
REQ-009 load_ready  output  1  loader accepts a byte this cycle.
REQ-010 ext_value  output  8  value driven onto the machine bus via the external-read path.
REQ-011 en_read_external  output  1  machine bus selects ext_value.
REQ-012 en_write_mem_adr  output  1  machine memory address register loads from the bus.
REQ-013 en_write_mem  output  1  machine memory writes bus data at the latched address.
REQ-014 cpu_hold  output  1  holds the machine in reset while loading.
REQ-015 busy  output  1  state is not IDLE.
REQ-016 done  output  1  one-cycle pulse at end of session.
REQ-017 load_count  output  ADDR_W+1  bytes written in the current or last session.

Function
REQ-018 FSM states SHALL be IDLE, WAIT_BYTE, SET_ADR, WRITE, FINISH; all outputs SHALL be decoded from registered state (Moore); no input-to-output combinational path except none.
REQ-019 IDLE: start=1 -> WAIT_BYTE; addr <= 0; load_count <= 0; start in any other state SHALL be ignored.
REQ-020 WAIT_BYTE: load_ready=1, cpu_hold=1; load_valid=1 -> capture load_data, go SET_ADR; abort=1 (priority over load_valid) -> FINISH, byte not taken.
REQ-021 SET_ADR: en_read_external=1, en_write_mem_adr=1, ext_value={zeros, addr}; -> WRITE unconditionally.
REQ-022 WRITE: en_read_external=1, en_write_mem=1, ext_value=captured byte; addr and load_count increment; -> FINISH if addr was DEPTH-1 or abort=1, else WAIT_BYTE.
REQ-023 abort during SET_ADR SHALL NOT cut the write; the byte in flight completes in WRITE.
REQ-024 en_write_mem_adr and en_write_mem SHALL never be high in the same cycle; both SHALL only be high with en_read_external=1.
REQ-025 FINISH: done=1, cpu_hold=1, en_read_external=0; -> IDLE next cycle.
REQ-026 cpu_hold SHALL be 1 in WAIT_BYTE, SET_ADR, WRITE, FINISH; 0 in IDLE.
REQ-027 Byte accepted at cycle k: address strobe k+1, data strobe k+2, load_ready again k+3 (3 cycles/byte minimum).
REQ-028 start at cycle n -> load_ready=1 at n+1.
REQ-029 ext_value SHALL be 0 whenever en_read_external=0.
REQ-030 addr SHALL not wrap inside a session; load_count saturates at DEPTH and holds until next start.

Reset
REQ-031 reset=1 SHALL force IDLE within the same cycle: addr=0, load_count=0, captured byte=0, all outputs 0, mid-session included; partially written RAM is not restored.
REQ-032 After reset deassertion the loader SHALL wait in IDLE for start.

Verification
REQ-033 Full load: start, 16 bytes 0x10..0x1F with load_valid held high -> per byte address strobe ext_value=0x0i then data strobe 0x1i, done at cycle 49 after start, load_count=16, cpu_hold low at cycle 50.
REQ-034 Stall: load_valid low 5 cycles before byte 3 -> load_ready stays 1, no strobes during gap, address 2 written with correct data afterward.
REQ-035 Abort in WAIT_BYTE after 4 bytes -> FINISH next cycle, done pulse, load_count=4, no further strobes.
REQ-036 Abort in SET_ADR of byte 7 -> byte 7 still written, then FINISH, load_count=7.
REQ-037 Reset asserted mid-WRITE of byte 5 -> all outputs 0 immediately, IDLE, start ignored while reset high; new start restarts at address 0.
REQ-038 start pulsed during busy -> ignored; session sequence and load_count unchanged.
